// File: rtl/mmio_bus_pkg.sv
// Shared constants for the memory-mapped bus: region map, per-slave wait
// states, timeout limit, slave indices and the controller state encoding.
package mmio_bus_pkg;

    localparam int          REGION_SHIFT = 16;
    localparam int          REGION_BITS  = 64 - REGION_SHIFT;

    localparam logic [63:0] RAM_BASE = 64'h0000_0000_0000_0000;
    localparam logic [63:0] VGA_BASE = 64'h0000_0000_0001_0000;
    localparam logic [63:0] KBD_BASE = 64'h0000_0000_0002_0000;

    localparam int RAM_IDX = 0;
    localparam int VGA_IDX = 1;
    localparam int KBD_IDX = 2;

    localparam logic [3:0]  RAM_WAIT = 4'd0;
    localparam logic [3:0]  VGA_WAIT = 4'd1;
    localparam logic [3:0]  KBD_WAIT = 4'd0;
    localparam logic [3:0]  TIMEOUT  = 4'd15;

    localparam logic [63:0] ERROR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERROR
    } bus_state_e;

    function automatic logic [3:0] slaveWait(input logic [2:0] onehot);
        if (onehot[VGA_IDX]) return VGA_WAIT;
        if (onehot[KBD_IDX]) return KBD_WAIT;
        return RAM_WAIT;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational region decoder: upper address bits -> one-hot slave select,
// RAM winning over VGA over KBD if regions ever overlap.
module mmio_decode
    import mmio_bus_pkg::*;
(
    input  logic [REGION_BITS-1:0] region_i,
    output logic [2:0]             sel_o,
    output logic                   unmapped_o
);

    logic ramHit;
    logic vgaHit;
    logic kbdHit;

    assign ramHit = (region_i == RAM_BASE[63:REGION_SHIFT]);
    assign vgaHit = (region_i == VGA_BASE[63:REGION_SHIFT]);
    assign kbdHit = (region_i == KBD_BASE[63:REGION_SHIFT]);

    always_comb begin
        sel_o = 3'b000;
        if (ramHit)      sel_o[RAM_IDX] = 1'b1;
        else if (vgaHit) sel_o[VGA_IDX] = 1'b1;
        else if (kbdHit) sel_o[KBD_IDX] = 1'b1;
    end

    assign unmapped_o = (sel_o == 3'b000);

endmodule

// File: rtl/mmio_bus_controller.sv
// Sequences core loads/stores onto the shared MMIO bus: decodes the slave,
// inserts wait states, stalls the core and flags unmapped or timed-out accesses.
module mmio_bus_controller
    import mmio_bus_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  cpu_address,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [63:0]  cpu_wdata,
    output logic [63:0]  cpu_rdata,
    output logic         stall,
    output logic         bus_error,
    output logic [63:0]  bus_address,
    output logic [63:0]  bus_wdata,
    output logic         bus_read,
    output logic         bus_write,
    output logic [2:0]   sel,
    input  logic [191:0] slave_rdata,
    input  logic [2:0]   slave_ready
);

    bus_state_e  state_q;
    logic [3:0]  waitCnt_q;
    logic [3:0]  toCnt_q;
    logic [2:0]  sel_q;
    logic        busRead_q;
    logic        busWrite_q;
    logic        busError_q;
    logic [63:0] rdata_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    logic [2:0]  decSel;
    logic        decUnmapped;
    logic [63:0] slaveWord;
    logic        slaveReady;
    logic        cpuReq;
    logic        reqIllegal;

    mmio_decode uDecode (
        .region_i   (cpu_address[63:REGION_SHIFT]),
        .sel_o      (decSel),
        .unmapped_o (decUnmapped)
    );

    assign cpuReq     = cpu_read | cpu_write;
    assign reqIllegal = (cpu_read & cpu_write) | (cpuReq & decUnmapped);

    // Only the latched slave's data and ready are ever looked at.
    always_comb begin
        slaveWord  = slave_rdata[63:0];
        slaveReady = slave_ready[RAM_IDX];
        if (sel_q[VGA_IDX]) begin
            slaveWord  = slave_rdata[127:64];
            slaveReady = slave_ready[VGA_IDX];
        end else if (sel_q[KBD_IDX]) begin
            slaveWord  = slave_rdata[191:128];
            slaveReady = slave_ready[KBD_IDX];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= 4'd0;
            toCnt_q    <= 4'd0;
            sel_q      <= 3'b000;
            busRead_q  <= 1'b0;
            busWrite_q <= 1'b0;
            busError_q <= 1'b0;
            rdata_q    <= 64'd0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
        end else begin
            busError_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (reqIllegal) begin
                        state_q    <= ST_ERROR;
                        busError_q <= 1'b1;
                        rdata_q    <= ERROR_DATA;
                    end else if (cpuReq) begin
                        state_q    <= ST_ACCESS;
                        addr_q     <= cpu_address;
                        wdata_q    <= cpu_wdata;
                        busRead_q  <= cpu_read;
                        busWrite_q <= cpu_write;
                        sel_q      <= decSel;
                        waitCnt_q  <= slaveWait(decSel);
                        toCnt_q    <= 4'd0;
                    end
                end
                ST_ACCESS: begin
                    toCnt_q <= toCnt_q + 4'd1;
                    if (waitCnt_q != 4'd0) begin
                        waitCnt_q <= waitCnt_q - 4'd1;
                    end
                    // Completion wins over timeout when both land on the same cycle.
                    if ((waitCnt_q == 4'd0) && slaveReady) begin
                        if (busRead_q) rdata_q <= slaveWord;
                        state_q    <= ST_DONE;
                        sel_q      <= 3'b000;
                        busRead_q  <= 1'b0;
                        busWrite_q <= 1'b0;
                    end else if (toCnt_q == (TIMEOUT - 4'd1)) begin
                        state_q    <= ST_ERROR;
                        busError_q <= 1'b1;
                        rdata_q    <= ERROR_DATA;
                        sel_q      <= 3'b000;
                        busRead_q  <= 1'b0;
                        busWrite_q <= 1'b0;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                ST_ERROR: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall       = (state_q == ST_IDLE) ? cpuReq : (state_q == ST_ACCESS);
    assign bus_error   = busError_q;
    assign cpu_rdata   = rdata_q;
    assign bus_address = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_read    = busRead_q;
    assign bus_write   = busWrite_q;
    assign sel         = sel_q;

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Randomized self-checking bench for mmio_bus_controller; each transaction's
// timeline is predicted from wait states, ready delay and timeout rules.
module tb_mmio_bus_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic [63:0]  cpu_address;
    logic         cpu_read;
    logic         cpu_write;
    logic [63:0]  cpu_wdata;
    logic [63:0]  cpu_rdata;
    logic         stall;
    logic         bus_error;
    logic [63:0]  bus_address;
    logic [63:0]  bus_wdata;
    logic         bus_read;
    logic         bus_write;
    logic [2:0]   sel;
    logic [191:0] slave_rdata;
    logic [2:0]   slave_ready;

    logic [63:0]  ramWord;
    logic [63:0]  vgaWord;
    logic [63:0]  kbdWord;
    logic [63:0]  expRdata;

    int vectorCount = 0;
    int missCount   = 0;

    assign slave_rdata = {kbdWord, vgaWord, ramWord};

    always #5 clock = ~clock;

    mmio_bus_controller dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .stall       (stall),
        .bus_error   (bus_error),
        .bus_address (bus_address),
        .bus_wdata   (bus_wdata),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .sel         (sel),
        .slave_rdata (slave_rdata),
        .slave_ready (slave_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // op: 0 read, 1 write, 2 read+write. region: 0 RAM, 1 VGA, 2 KBD, 3 unmapped.
    // Selected slave's ready is high on ACCESS cycles numbered above readyDelay.
    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic applyStimulus(input int op, input int region, input int readyDelay,
                                 input logic [63:0] addr, input logic [63:0] data);
        int          waitStates;
        int          firstDone;
        int          finish;
        logic        errExp;
        logic [2:0]  selExp;
        logic [63:0] wordExp;

        ramWord = {$urandom, $urandom};
        vgaWord = {$urandom, $urandom};
        kbdWord = {$urandom, $urandom};
        wordExp = (region == 0) ? ramWord : (region == 1) ? vgaWord : kbdWord;
        waitStates = (region == 1) ? 1 : 0;
        selExp = (region < 3) ? 3'(1 << region) : 3'b000;
        firstDone = ((waitStates > readyDelay) ? waitStates : readyDelay) + 1;

        if (op == 2 || region == 3) begin
            errExp = 1'b1;
            finish = 1;
        end else if (firstDone <= 15) begin
            errExp = 1'b0;
            finish = firstDone + 1;
        end else begin
            errExp = 1'b1;
            finish = 16;
        end

        for (int c = 0; c <= finish; c++) begin
            cpu_address = addr;
            cpu_wdata   = data;
            cpu_read    = (c < finish) && (op != 1);
            cpu_write   = (c < finish) && (op != 0);
            slave_ready = 3'($urandom_range(0, 7));
            if (region < 3) slave_ready[region] = (c > readyDelay);
            @(negedge clock);
            if (c == 0) begin
                checkOutput("req_stall", stall, 1'b1);
                checkOutput("req_sel", sel, 3'b000);
                checkOutput("req_err", bus_error, 1'b0);
            end else if (c < finish) begin
                checkOutput("acc_stall", stall, 1'b1);
                checkOutput("acc_sel", sel, selExp);
                checkOutput("acc_rd", bus_read, op == 0);
                checkOutput("acc_wr", bus_write, op == 1);
                checkOutput("acc_addr", bus_address, addr);
                checkOutput("acc_wdata", bus_wdata, data);
                checkOutput("acc_err", bus_error, 1'b0);
            end else begin
                if (errExp) expRdata = 64'hFFFF_FFFF_FFFF_FFFF;
                else if (op == 0) expRdata = wordExp;
                checkOutput("end_stall", stall, 1'b0);
                checkOutput("end_sel", sel, 3'b000);
                checkOutput("end_rd", bus_read, 1'b0);
                checkOutput("end_wr", bus_write, 1'b0);
                checkOutput("end_err", bus_error, errExp);
                checkOutput("end_rdata", cpu_rdata, expRdata);
            end
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checkOutput("idle_err", bus_error, 1'b0);
        checkOutput("idle_stall", stall, 1'b0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int          op;
        int          region;
        int          delay;
        logic [63:0] addr;

        reset       = 1'b1;
        cpu_address = 64'd0;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_wdata   = 64'd0;
        slave_ready = 3'b000;
        ramWord     = 64'd0;
        vgaWord     = 64'd0;
        kbdWord     = 64'd0;
        expRdata    = 64'd0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_sel", sel, 3'b000);
        checkOutput("rst_rdata", cpu_rdata, 64'd0);
        checkOutput("rst_addr", bus_address, 64'd0);
        checkOutput("rst_err", bus_error, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        applyStimulus(0, 0, 0, 64'h10, {$urandom, $urandom});
        applyStimulus(1, 1, 0, 64'h10008, 64'h41);
        applyStimulus(0, 2, 5, 64'h20000, 64'd0);
        applyStimulus(0, 3, 0, 64'h90000, 64'd0);
        applyStimulus(0, 0, 99, 64'h40, 64'd0);
        applyStimulus(0, 0, 14, 64'h48, 64'd0);
        applyStimulus(1, 2, 15, 64'h20010, 64'h1234);
        applyStimulus(2, 0, 0, 64'h18, 64'd0);

        // Reset in the middle of a VGA access.
        cpu_read    = 1'b1;
        cpu_address = 64'h10020;
        slave_ready = 3'b000;
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("pre_rst_sel", sel, 3'b010);
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("mid_rst_sel", sel, 3'b000);
        checkOutput("mid_rst_rd", bus_read, 1'b0);
        checkOutput("mid_rst_stall", stall, 1'b0);
        checkOutput("mid_rst_err", bus_error, 1'b0);
        checkOutput("mid_rst_addr", bus_address, 64'd0);
        checkOutput("mid_rst_rdata", cpu_rdata, 64'd0);
        reset    = 1'b0;
        expRdata = 64'd0;
        @(posedge clock);
        #1;
        applyStimulus(0, 0, 1, 64'h100, 64'd0);

        for (int n = 0; n < 60; n++) begin
            op     = $urandom_range(0, 9);
            op     = (op < 5) ? 0 : (op < 9) ? 1 : 2;
            region = $urandom_range(0, 3);
            delay  = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
            addr   = {$urandom, $urandom};
            if (region < 3) addr[63:16] = 48'(region);
            else if (addr[63:16] < 48'd3) addr[63:16] = 48'd7;
            applyStimulus(op, region, delay, addr, {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
